// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port: one access per cycle, read data returned on the following cycle.
interface data_sram_responder_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output we, output addr, output wdata, input rdata);
   modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM slave: word RAM plus an MMIO register file with a free-running timer,
// compare-match interrupt and synchronised switches. Fixed one-cycle read latency.
module data_sram_responder #(
   parameter int          RAM_AW    = 14,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   data_sram_responder_if.slave  data_sram,
   output logic [15:0]           led,
   input  logic [7:0]            switch_in,
   output logic                  timer_irq
);

   localparam logic [13:0] OFF_LED     = 14'h0000;
   localparam logic [13:0] OFF_SWITCH  = 14'h0001;
   localparam logic [13:0] OFF_TIMER   = 14'h0002;
   localparam logic [13:0] OFF_COMPARE = 14'h0003;
   localparam logic [13:0] OFF_STATUS  = 14'h0004;
   localparam logic [13:0] OFF_SCRATCH = 14'h0005;

   logic [31:0] mem [0:(1<<RAM_AW)-1];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] compare_q, compare_d;
   logic        status_q, status_d;
   logic [31:0] scratch_q, scratch_d;
   logic [7:0]  sw_meta_q, sw_sync_q;

   logic              mmio_hit;
   logic              wr_en;
   logic [13:0]       mmio_off;
   logic [RAM_AW-1:0] ram_idx;
   logic [31:0]       mmio_rdata;
   logic [31:0]       led_merged;
   logic              match;
   logic              w1c;
   logic [1:0]        unused_addr;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   assign mmio_hit    = (data_sram.addr[31:16] == MMIO_BASE[31:16]);
   assign wr_en       = data_sram.en && (data_sram.we != 4'h0);
   assign mmio_off    = data_sram.addr[15:2];
   assign ram_idx     = data_sram.addr[RAM_AW+1:2];
   assign unused_addr = data_sram.addr[1:0];
   assign match       = (timer_q == compare_q);
   assign w1c         = wr_en && mmio_hit && (mmio_off == OFF_STATUS)
                        && data_sram.we[0] && data_sram.wdata[0];

   always_comb begin
      mmio_rdata = 32'h0;
      case (mmio_off)
         OFF_LED:     mmio_rdata = {16'h0, led_q};
         OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync_q};
         OFF_TIMER:   mmio_rdata = timer_q;
         OFF_COMPARE: mmio_rdata = compare_q;
         OFF_STATUS:  mmio_rdata = {31'h0, status_q};
         OFF_SCRATCH: mmio_rdata = scratch_q;
         default:     mmio_rdata = 32'h0;
      endcase
   end

   // A CPU write to TIMER overrides the increment only in the lanes it writes.
   always_comb begin
      rdata_d    = rdata_q;
      led_d      = led_q;
      timer_d    = timer_q + 32'd1;
      compare_d  = compare_q;
      scratch_d  = scratch_q;
      status_d   = match | (status_q & ~w1c);
      led_merged = merge_bytes({16'h0, led_q}, data_sram.wdata, data_sram.we & 4'b0011);

      if (data_sram.en)
         rdata_d = mmio_hit ? mmio_rdata : mem[ram_idx];

      if (wr_en && mmio_hit) begin
         case (mmio_off)
            OFF_LED:     led_d     = led_merged[15:0];
            OFF_TIMER:   timer_d   = merge_bytes(timer_q + 32'd1, data_sram.wdata, data_sram.we);
            OFF_COMPARE: compare_d = merge_bytes(compare_q, data_sram.wdata, data_sram.we);
            OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram.wdata, data_sram.we);
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !mmio_hit) begin
         for (int i = 0; i < 4; i++)
            if (data_sram.we[i]) mem[ram_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         timer_q   <= 32'h0;
         compare_q <= 32'hFFFF_FFFF;
         status_q  <= 1'b0;
         scratch_q <= 32'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         compare_q <= compare_d;
         status_q  <= status_d;
         scratch_q <= scratch_d;
         sw_meta_q <= switch_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign data_sram.rdata = rdata_q;
   assign led             = led_q;
   assign timer_irq       = status_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised bench for data_sram_responder: every cycle is predicted by a transaction-level
// model of the RAM and MMIO registers and compared against rdata, led and timer_irq.
module tb_data_sram_responder;

   localparam logic [31:0] A_LED     = 32'hBFAF_0000;
   localparam logic [31:0] A_SWITCH  = 32'hBFAF_0004;
   localparam logic [31:0] A_TIMER   = 32'hBFAF_0008;
   localparam logic [31:0] A_COMPARE = 32'hBFAF_000C;
   localparam logic [31:0] A_STATUS  = 32'hBFAF_0010;
   localparam logic [31:0] A_UNMAP   = 32'hBFAF_0040;

   logic        clk;
   logic        resetn;
   logic [15:0] led;
   logic [7:0]  switchIn;
   logic        timerIrq;

   int checks   = 0;
   int failures = 0;

   data_sram_responder_if sramIf ();

   data_sram_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .data_sram (sramIf),
      .led       (led),
      .switch_in (switchIn),
      .timer_irq (timerIrq)
   );

   always #5 clk = ~clk;

   logic [31:0] ramM [int];
   logic [31:0] mRdata, mTimer, mCompare, mScratch;
   logic [15:0] mLed;
   logic        mStatus;
   logic [7:0]  mSw1, mSw2, swIn;

   function automatic logic [31:0] mergeLanes(input logic [31:0] oldV, input logic [31:0] newV,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = oldV;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = newV[8*i +: 8];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      mRdata   = 32'h0;
      mLed     = 16'h0;
      mTimer   = 32'h0;
      mCompare = 32'hFFFF_FFFF;
      mStatus  = 1'b0;
      mScratch = 32'h0;
      mSw1     = 8'h0;
      mSw2     = 8'h0;
   endtask

   // Drives one access, predicts the effect of the coming edge, then checks just after it.
   task automatic applyStimulus(input bit en, input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      logic        hit, wr;
      logic [15:0] off;
      int          key;
      logic [31:0] rd, nTimer, nCompare, nScratch, nRdata, ledWide;
      logic [15:0] nLed;
      logic        nStatus;
      sramIf.en    = en;
      sramIf.we    = we;
      sramIf.addr  = addr;
      sramIf.wdata = wdata;
      switchIn     = swIn;

      hit = (addr[31:16] == 16'hBFAF);
      off = {addr[15:2], 2'b00};
      key = int'(addr[15:2]);
      wr  = en && (we != 4'h0);

      rd = 32'h0;
      if (hit) begin
         case (off)
            16'h0000: rd = {16'h0, mLed};
            16'h0004: rd = {24'h0, mSw2};
            16'h0008: rd = mTimer;
            16'h000C: rd = mCompare;
            16'h0010: rd = {31'h0, mStatus};
            16'h0014: rd = mScratch;
            default:  rd = 32'h0;
         endcase
      end else begin
         rd = ramM.exists(key) ? ramM[key] : 32'hx;
      end
      nRdata = en ? rd : mRdata;

      nLed     = mLed;
      nTimer   = mTimer + 32'd1;
      nCompare = mCompare;
      nScratch = mScratch;
      nStatus  = (mTimer == mCompare) ? 1'b1 : mStatus;
      if (wr && hit) begin
         case (off)
            16'h0000: begin
               ledWide = mergeLanes({16'h0, mLed}, wdata, we);
               nLed    = ledWide[15:0];
            end
            16'h0008: nTimer   = mergeLanes(nTimer, wdata, we);
            16'h000C: nCompare = mergeLanes(mCompare, wdata, we);
            16'h0010: if (we[0] && wdata[0] && (mTimer != mCompare)) nStatus = 1'b0;
            16'h0014: nScratch = mergeLanes(mScratch, wdata, we);
            default: ;
         endcase
      end
      if (wr && !hit)
         ramM[key] = mergeLanes(ramM.exists(key) ? ramM[key] : 32'h0, wdata, we);

      @(posedge clk);
      #1;
      mRdata   = nRdata;
      mLed     = nLed;
      mTimer   = nTimer;
      mCompare = nCompare;
      mScratch = nScratch;
      mStatus  = nStatus;
      mSw2     = mSw1;
      mSw1     = swIn;

      checkOutput("rdata", sramIf.rdata, mRdata);
      checkOutput("led", {16'h0, led}, {16'h0, mLed});
      checkOutput("irq", {31'h0, timerIrq}, {31'h0, mStatus});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          cyc;
      int          offs [8] = '{'h0, 'h4, 'h8, 'hC, 'h10, 'h14, 'h40, 'h1C};
      logic [15:0] uppers [4] = '{16'h0000, 16'h0001, 16'h1FC0, 16'h8000};
      logic [31:0] a, d;
      logic [3:0]  w;

      clk          = 1'b0;
      resetn       = 1'b0;
      swIn         = 8'h0;
      switchIn     = 8'h0;
      sramIf.en    = 1'b0;
      sramIf.we    = 4'h0;
      sramIf.addr  = 32'h0;
      sramIf.wdata = 32'h0;
      resetModel();
      #1;
      checkOutput("resetRdata", sramIf.rdata, 32'h0);
      checkOutput("resetLed", {16'h0, led}, 32'h0);
      checkOutput("resetIrq", {31'h0, timerIrq}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 4'hF, 32'(i << 2), $urandom);

      applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
      applyStimulus(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_AA00);
      applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      checkOutput("ramByteLane", sramIf.rdata, 32'h1122_AA44);
      applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
      checkOutput("readFirst", sramIf.rdata, 32'h1122_AA44);
      applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      checkOutput("readNew", sramIf.rdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 4'h0, 32'h0000_0000, 32'h0);
         checkOutput("rdataHold", sramIf.rdata, 32'hDEAD_BEEF);
      end

      applyStimulus(1'b1, 4'hF, A_LED, 32'h0001_A5A5);
      checkOutput("ledWrite", {16'h0, led}, 32'h0000_A5A5);
      applyStimulus(1'b1, 4'h0, A_LED, 32'h0);
      checkOutput("ledRead", sramIf.rdata, 32'h0000_A5A5);
      swIn = 8'h3C;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 4'h0, A_SWITCH, 32'h0);
      checkOutput("switchRead", sramIf.rdata, 32'h0000_003C);
      applyStimulus(1'b1, 4'h0, A_UNMAP, 32'h0);
      checkOutput("unmappedRead", sramIf.rdata, 32'h0);

      applyStimulus(1'b1, 4'hF, A_COMPARE, 32'd10);
      applyStimulus(1'b1, 4'hF, A_STATUS, 32'd1);
      applyStimulus(1'b1, 4'hF, A_TIMER, 32'd0);
      cyc = 0;
      while (!timerIrq && cyc < 20) begin
         applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
         cyc++;
      end
      checkOutput("irqLatency", 32'(cyc), 32'd11);
      applyStimulus(1'b1, 4'hF, A_STATUS, 32'd1);
      checkOutput("irqClear", {31'h0, timerIrq}, 32'h0);
      applyStimulus(1'b1, 4'hF, A_TIMER, 32'd8);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 4'hF, A_STATUS, 32'd1);
      checkOutput("irqSetWins", {31'h0, timerIrq}, 32'h1);

      applyStimulus(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
      checkOutput("timerWrap", sramIf.rdata, 32'h0);

      applyStimulus(1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
      applyStimulus(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      checkOutput("ramAlias", sramIf.rdata, 32'hCAFE_F00D);

      for (int n = 0; n < 400; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 7) == 0) swIn = 8'($urandom);
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         d = $urandom;
         if (kind < 2) begin
            applyStimulus(1'b0, 4'($urandom), $urandom, d);
         end else if (kind < 6) begin
            a = {uppers[$urandom_range(0, 3)], 16'($urandom_range(0, 15) << 2)};
            applyStimulus(1'b1, w, a, d);
         end else begin
            a = 32'hBFAF_0000 | 32'(offs[$urandom_range(0, 7)]);
            if (a == A_TIMER) d = mCompare - 32'($urandom_range(0, 4));
            applyStimulus(1'b1, w, a, d);
         end
      end

      applyStimulus(1'b1, 4'hF, A_LED, 32'h0000_5A5A);
      applyStimulus(1'b1, 4'h0, 32'h0000_0004, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("asyncRstRdata", sramIf.rdata, 32'h0);
      checkOutput("asyncRstLed", {16'h0, led}, 32'h0);
      checkOutput("asyncRstIrq", {31'h0, timerIrq}, 32'h0);
      resetModel();
      swIn = 8'h0;
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(1'b1, 4'h0, A_TIMER, 32'h0);
      checkOutput("timerAfterRst", sramIf.rdata, 32'h0);
      applyStimulus(1'b1, 4'h0, A_STATUS, 32'h0);
      checkOutput("statusAfterRst", sramIf.rdata, 32'h0);
      for (int n = 0; n < 40; n++)
         applyStimulus(1'b1, 4'h0, 32'(n % 16) << 2, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
